// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer
//   Two-entry operand/opcode buffer feeding the logic/arith/shift ALU units.
//   Opcodes are decoded at enqueue; only the decoded selects are stored.
//   One op per cycle throughput, one cycle latency from accept to present.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of all buffered entries
//   in_valid/in_ready   upstream handshake (in_ready derived from registered state)
//   in_a, in_b, in_op   operands and 4-bit opcode
//   out_valid/out_ready ALU-side handshake for the head entry
//   out_a, out_b        head operands
//   out_alu_op0/1       decoded sub-op selects
//   out_unit            0=logic 1=arith 2=shift 3=illegal
//   out_illegal         head opcode is illegal
//   illegal_cnt         saturating count of illegal ops popped
//
// State table
//   state    | meaning
//   ST_EMPTY | no entries, out_valid low
//   ST_ONE   | ent0 holds the head
//   ST_FULL  | ent0 head, ent1 second; in_ready low
module alu_issue_buffer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_alu_op0,
  output logic             out_alu_op1,
  output logic [1:0]       out_unit,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op0;
    logic             op1;
    logic [1:0]       unit;
    logic             ill;
  } entry_t;

  state_t state, state_nxt;
  entry_t ent0, ent1, ent_in;
  logic   push, pop;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Decode at enqueue. Logic, arith and shift all map in_op[1:0] straight
  // onto {op0, op1}; only the illegal group overrides the selects.
  always_comb begin
    ent_in.a    = in_a;
    ent_in.b    = in_b;
    ent_in.op0  = in_op[1];
    ent_in.op1  = in_op[0];
    ent_in.unit = in_op[3:2];
    ent_in.ill  = 1'b0;
    if (in_op[3:2] == 2'b11) begin
      ent_in.op0 = 1'b0;
      ent_in.op1 = 1'b0;
      ent_in.ill = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) state_nxt = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_nxt = ST_FULL;
          else if (pop && !push) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Outputs from state. in_ready depends only on the registered state (plus
  // reset gating), so a pop at full frees the slot the following cycle.
  always_comb begin
    out_valid = (state != ST_EMPTY);
    in_ready  = rst_n & (state != ST_FULL);
  end

  // Payload: ent0 is always the head. ent1 is only written when a push
  // lands behind an existing head that is not leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
    end else if (!flush) begin
      case (state)
        ST_EMPTY: if (push) ent0 <= ent_in;
        ST_ONE: begin
          if (push && pop) ent0 <= ent_in;
          else if (push)   ent1 <= ent_in;
        end
        ST_FULL:  if (pop) ent0 <= ent1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (pop && ent0.ill && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_a       = ent0.a;
  assign out_b       = ent0.b;
  assign out_alu_op0 = ent0.op0;
  assign out_alu_op1 = ent0.op1;
  assign out_unit    = ent0.unit;
  assign out_illegal = ent0.ill;

endmodule

// File: tb/tb_alu_issue_buffer.sv
module tb_alu_issue_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic        out_alu_op0, out_alu_op1;
  logic [1:0]  out_unit;
  logic        out_illegal;
  logic [7:0]  illegal_cnt;

  alu_issue_buffer #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_alu_op0(out_alu_op0), .out_alu_op1(out_alu_op1),
    .out_unit(out_unit), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op0;
    logic        op1;
    logic [1:0]  unit;
    logic        ill;
  } ent_t;

  typedef struct {
    logic [3:0] op;
    logic       op0;
    logic       op1;
    logic [1:0] unit;
    logic       ill;
  } dec_vec_t;

  ent_t       q[$];
  logic [7:0] m_ill = 8'd0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         dut_pops = 0;
  logic       last_push = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the opcode table: group picks the unit,
  // the low two bits are the selects, group 3 traps with zero selects.
  function automatic ent_t model_decode(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    ent_t e;
    e.a = a;
    e.b = b;
    e.unit = op[3:2];
    e.ill  = (op[3:2] == 2'd3);
    e.op0  = e.ill ? 1'b0 : op[1];
    e.op1  = e.ill ? 1'b0 : op[0];
    return e;
  endfunction

  // Drive one cycle, check visible state against the model, clock, update model.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic rdy, input logic fl);
    logic do_push, do_pop;
    ent_t e;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = rdy; flush = fl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
    if (q.size() != 0) begin
      chk("head_a", out_a, q[0].a);
      chk("head_b", out_b, q[0].b);
      chk("head_op0", 32'(out_alu_op0), 32'(q[0].op0));
      chk("head_op1", 32'(out_alu_op1), 32'(q[0].op1));
      chk("head_unit", 32'(out_unit), 32'(q[0].unit));
      chk("head_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
    if (out_valid && rdy && !fl) dut_pops++;
    do_push = v && (q.size() != 2) && !fl;
    do_pop  = (q.size() != 0) && rdy && !fl;
    e = model_decode(a, b, op);
    last_push = do_push;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop) begin
        if (q[0].ill && m_ill != 8'hFF) m_ill = m_ill + 8'd1;
        void'(q.pop_front());
      end
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_unit_ops", {28'd0, out_unit, out_alu_op0, out_alu_op1}, 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    q.delete();
    m_ill = 8'd0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  dec_vec_t vec[16];

  initial begin
    logic [31:0] ra, rb, sv;
    logic [3:0]  rop;
    logic        rv, pend;
    int          p0;

    vec[0]  = '{4'h0, 1'b0, 1'b0, 2'd0, 1'b0};
    vec[1]  = '{4'h1, 1'b0, 1'b1, 2'd0, 1'b0};
    vec[2]  = '{4'h2, 1'b1, 1'b0, 2'd0, 1'b0};
    vec[3]  = '{4'h3, 1'b1, 1'b1, 2'd0, 1'b0};
    vec[4]  = '{4'h4, 1'b0, 1'b0, 2'd1, 1'b0};
    vec[5]  = '{4'h5, 1'b0, 1'b1, 2'd1, 1'b0};
    vec[6]  = '{4'h6, 1'b1, 1'b0, 2'd1, 1'b0};
    vec[7]  = '{4'h7, 1'b1, 1'b1, 2'd1, 1'b0};
    vec[8]  = '{4'h8, 1'b0, 1'b0, 2'd2, 1'b0};
    vec[9]  = '{4'h9, 1'b0, 1'b1, 2'd2, 1'b0};
    vec[10] = '{4'hA, 1'b1, 1'b0, 2'd2, 1'b0};
    vec[11] = '{4'hB, 1'b1, 1'b1, 2'd2, 1'b0};
    vec[12] = '{4'hC, 1'b0, 1'b0, 2'd3, 1'b1};
    vec[13] = '{4'hD, 1'b0, 1'b0, 2'd3, 1'b1};
    vec[14] = '{4'hE, 1'b0, 1'b0, 2'd3, 1'b1};
    vec[15] = '{4'hF, 1'b0, 1'b0, 2'd3, 1'b1};

    #3;
    do_reset();

    // 1: single op, one-cycle latency, drains next cycle
    cycle(1'b1, 32'hF0F0_0000, 32'h0FF0_FFFF, 4'b0011, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sel", {29'd0, out_unit, out_alu_op0, out_alu_op1}, 32'b0011);
    chk("t1_a", out_a, 32'hF0F0_0000);
    chk("t1_b", out_b, 32'h0FF0_FFFF);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t1_drained", 32'(out_valid), 32'd0);

    // 2: backpressure, third op held, ordered release
    cycle(1'b1, 32'h10, 32'h11, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 32'h21, 4'd1, 1'b0, 1'b0);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h30, 32'h31, 4'd2, 1'b0, 1'b0);
    chk("t2_head_first", out_a, 32'h10);
    cycle(1'b1, 32'h30, 32'h31, 4'd2, 1'b1, 1'b0);
    chk("t2_ready_after_pop", 32'(in_ready), 32'd1);
    chk("t2_head_second", out_a, 32'h20);
    cycle(1'b1, 32'h30, 32'h31, 4'd2, 1'b1, 1'b0);
    chk("t2_head_third", out_a, 32'h30);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);

    // 3: 16 back-to-back arith ops
    p0 = dut_pops;
    for (int i = 0; i < 16; i++)
      cycle(1'b1, $urandom, $urandom, 4'(4 + (i % 4)), 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t3_pop_count", 32'(dut_pops - p0), 32'd16);

    // decode table
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'(i), ~32'(i), vec[i].op, 1'b1, 1'b0);
      chk("dec_op0", 32'(out_alu_op0), 32'(vec[i].op0));
      chk("dec_op1", 32'(out_alu_op1), 32'(vec[i].op1));
      chk("dec_unit", 32'(out_unit), 32'(vec[i].unit));
      chk("dec_illegal", 32'(out_illegal), 32'(vec[i].ill));
    end
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);

    // randomized traffic, upstream holds data while stalled
    pend = 1'b0; ra = '0; rb = '0; rop = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        ra = $urandom; rb = $urandom; rop = 4'($urandom_range(0, 15));
        rv = ($urandom_range(0, 3) != 0);
      end else begin
        rv = 1'b1;
      end
      cycle(rv, ra, rb, rop, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
      pend = rv && !last_push;
    end

    // 4: illegal ops and counter saturation
    do_reset();
    cycle(1'b1, 32'hA, 32'hB, 4'b1100, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 32'hD, 4'b1111, 1'b0, 1'b0);
    chk("t4_cnt0", 32'(illegal_cnt), 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t4_cnt1", 32'(illegal_cnt), 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t4_cnt2", 32'(illegal_cnt), 32'd2);
    for (int i = 0; i < 255; i++)
      cycle(1'b1, $urandom, $urandom, 4'(12 + (i % 4)), 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t4_saturated", 32'(illegal_cnt), 32'hFF);

    // 5: flush while full and offering
    do_reset();
    cycle(1'b1, 32'h1, 32'h2, 4'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'h3, 32'h4, 4'h5, 1'b0, 1'b0);
    sv = 32'(m_ill);
    cycle(1'b1, 32'h5, 32'h6, 4'h9, 1'b1, 1'b1);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_cnt", 32'(illegal_cnt), sv);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t5_no_ghost", 32'(out_valid), 32'd0);

    // 6: reset mid-stream at full
    cycle(1'b1, 32'h7, 32'h8, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 32'h9, 32'hA, 4'h2, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("t6_no_stale", 32'(out_valid), 32'd0);
    cycle(1'b1, 32'h55, 32'h66, 4'h6, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_buffer.md
# alu_issue_buffer

Two-entry operand/opcode buffer directly upstream of the logic unit and its sibling ALU units. It accepts `{A, B, opcode}` over a valid/ready handshake and decodes the opcode at enqueue into the two logic-unit select bits (`AluOp0`, `AluOp1`) and a unit select. It presents the head entry to the ALU datapath with its own valid/ready handshake. Full throughput is one operation per cycle, with one cycle of latency and a registered `in_ready` for downstream backpressure.

## Interface
- `WIDTH`, 32, operand width in bits.
- `CNT_W`, 8, width of the saturating illegal-op counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous; discards all buffered entries.
- `in_valid`  in  1  upstream offers an operation.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_op`  in  4  opcode.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  ALU consumes the head entry.
- `out_a`, `out_b`  out  WIDTH  head operands.
- `out_alu_op0`, `out_alu_op1`  out  1  logic/arith sub-op selects.
- `out_unit`  out  2  0=logic, 1=arith, 2=shift, 3=illegal.
- `out_illegal`  out  1  head opcode is illegal.
- `illegal_cnt`  out  CNT_W  count of illegal ops popped, saturating.

## Operation
- Storage: 2 entries of `{a, b, alu_op0, alu_op1, unit, illegal}`. Decoded fields are stored, not raw `in_op`.
- Decode of `in_op[3:2]`:
  - 00 logic, unit 0: `in_op[1:0]` = 00 OR, 01 NOR, 10 AND, 11 XOR. `alu_op0 = in_op[1]` selects the AND/XOR half; `alu_op1 = in_op[0]` selects NOR or XOR within the half.
  - 01 arith, unit 1: `{alu_op0, alu_op1} = in_op[1:0]`.
  - 10 shift, unit 2: `{alu_op0, alu_op1} = in_op[1:0]`.
  - 11 illegal: unit 3, `alu_op0 = alu_op1 = 0`, `illegal = 1`. The entry is still enqueued and forwarded so downstream can trap.
- Push occurs when `in_valid && in_ready && !flush`.
- Pop occurs when `out_valid && out_ready && !flush`.
- `count` (0..2) updates:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop.
- `out_valid = (count != 0)`.
- `in_ready = (count != 2)`, forced 0 while `rst_n` is low.
- Outputs always show the head entry, FIFO order. On pop with count 2, the second entry becomes head on the next cycle.
- `illegal_cnt` increments on each pop with `illegal = 1` and saturates at all-ones.
- Flush:
  - Next cycle `count = 0`.
  - Push and pop in the flush cycle are ignored; upstream must re-offer.
  - `illegal_cnt` is unchanged by flush.
- Payload registers are undefined-but-stable when `out_valid = 0`; the bench must not check them.

## Timing
- Reset (async assert, sync-clean deassert):
  - `count = 0`, `out_valid = 0`, all payload outputs 0, `illegal_cnt = 0`.
  - `in_ready = 0` during reset and 1 in the first cycle after deassert.
- Latency: an op pushed at edge k presents with `out_valid = 1` in cycle k+1, even if the buffer was empty.
- Throughput: with `out_ready` held 1, one push and one pop per cycle; count stays at 1.
- Full (count 2): `in_ready = 0`; upstream holds its data.
- Pop at full: `in_ready` returns to 1 in the following cycle, not combinationally.
- Empty with `out_ready = 1`: no pop, and count does not underflow.
- Upstream rule: `in_a`, `in_b`, `in_op` must be stable while `in_valid = 1 && in_ready = 0`.
- Buffer rule: the head entry is held stable while `out_valid = 1 && out_ready = 0`.
- Reset mid-operation: all entries are dropped immediately and outputs take their reset values.

## Test plan
1. Reset, then push op 4'b0011 with `A = 32'hF0F0_0000`, `B = 32'h0FF0_FFFF` and `out_ready = 1`.
   Required: cycle+1 shows `out_valid = 1`, `alu_op0 = 1`, `alu_op1 = 1`, `unit = 0`, operands unchanged. Cycle+2 shows `out_valid = 0`.
2. Hold `out_ready = 0` and push ops 0, 1, 2.
   Required: `in_ready` drops after the second accept and the third op is held. Releasing `out_ready` gives pops in order 0, 1, 2, with `in_ready = 1` one cycle after the first pop.
3. Stream 16 back-to-back arith ops with `out_ready = 1`.
   Required: 16 pops in 16 consecutive cycles, `unit = 1`, `in_ready` never 0.
4. Push ops 4'b1100 and 4'b1111, then pop both.
   Required: `out_illegal = 1`, `unit = 3`, `alu_op = 00` for each. `illegal_cnt` goes 0 → 1 → 2. Forcing 255 further illegal pops saturates the counter at 8'hFF.
5. Fill to 2 entries, then assert `flush` together with `in_valid = 1`.
   Required: next cycle `out_valid = 0`, `in_ready = 1`, and the flushed-cycle op is absent. `illegal_cnt` is unchanged.
6. Assert `rst_n = 0` mid-stream with count 2.
   Required: `out_valid` and `in_ready` go 0 asynchronously. After release, `in_ready = 1` and no stale entries appear.
